// File: rtl/gesture_arbiter.sv
// Merges four one-pulse gesture detectors into single move commands, rejecting multi-direction gestures.
// move_valid rises WINDOW edges after the first pulse and is held until move_ack or ack timeout.
module gesture_arbiter #(
  parameter int WINDOW      = 4,
  parameter int LOCKOUT_CYC = 1000,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ready,
  input  logic       up_det,
  input  logic       down_det,
  input  logic       left_det,
  input  logic       right_det,
  input  logic       move_ack,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       conflict,
  output logic       drop,
  output logic       busy,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, LOCKOUT} state_t;

  localparam logic [15:0] WIN_LOAD  = 16'(WINDOW - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYC - 1);
  localparam logic [15:0] TO_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam bit          TO_EN     = (ACK_TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        move_valid_q, move_valid_d;
  logic [1:0]  move_dir_q, move_dir_d;
  logic        conflict_q, conflict_d;
  logic        drop_q, drop_d;
  logic        busy_q, busy_d;
  logic [7:0]  move_count_q, move_count_d;

  logic [3:0]  det;
  logic [3:0]  pend_next;
  logic [1:0]  dir_enc;

  // Detectors are only trusted while the tracker reports a valid centre.
  assign det       = {right_det, left_det, down_det, up_det} & {4{ready}};
  assign pend_next = pending_q | det;

  always_comb begin
    dir_enc = 2'd0;
    case (pend_next)
      4'b0010: dir_enc = 2'd1;
      4'b0100: dir_enc = 2'd2;
      4'b1000: dir_enc = 2'd3;
      default: dir_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    move_valid_d = move_valid_q;
    move_dir_d   = move_dir_q;
    conflict_d   = 1'b0;
    drop_d       = 1'b0;
    move_count_d = move_count_q;
    case (state_q)
      IDLE: begin
        if (en && (det != 4'b0000)) begin
          pending_d = det;
          cnt_d     = WIN_LOAD;
          state_d   = COLLECT;
        end else begin
          pending_d = 4'b0000;
        end
      end
      COLLECT: begin
        if (!en) begin
          pending_d = 4'b0000;
          state_d   = IDLE;
        end else begin
          pending_d = pend_next;
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else if ($onehot(pend_next)) begin
            move_valid_d = 1'b1;
            move_dir_d   = dir_enc;
            tcnt_d       = 16'd0;
            state_d      = ISSUE;
          end else begin
            conflict_d = 1'b1;
            cnt_d      = LOCK_LOAD;
            state_d    = LOCKOUT;
          end
        end
      end
      ISSUE: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (move_ack) begin
          move_valid_d = 1'b0;
          move_count_d = move_count_q + 8'd1;
          cnt_d        = LOCK_LOAD;
          state_d      = LOCKOUT;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          move_valid_d = 1'b0;
          drop_d       = 1'b1;
          cnt_d        = LOCK_LOAD;
          state_d      = LOCKOUT;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      LOCKOUT: begin
        if (!en || (cnt_q == 16'd0)) begin
          pending_d = 4'b0000;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        pending_d = 4'b0000;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pending_q    <= 4'b0000;
      cnt_q        <= 16'd0;
      tcnt_q       <= 16'd0;
      move_valid_q <= 1'b0;
      move_dir_q   <= 2'd0;
      conflict_q   <= 1'b0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
      move_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      move_valid_q <= move_valid_d;
      move_dir_q   <= move_dir_d;
      conflict_q   <= conflict_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      move_count_q <= move_count_d;
    end
  end

  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;
  assign conflict   = conflict_q;
  assign drop       = drop_q;
  assign busy       = busy_q;
  assign move_count = move_count_q;

endmodule
